aes_inv_cipher_ctrl: RTL and testbench
======================================

# aes_inv_cipher_ctrl

Iterative AES-128 decryption sequencer. It accepts one 128-bit ciphertext block over a valid/ready handshake and fetches round keys by index from an external key store. It steps the inverse round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) one round per clock and presents the plaintext over a second valid/ready handshake. It sits between the block-input FIFO and the output formatter, and owns the only instance of the inverse round logic.

## Interface
- NR, 10, number of AES rounds; only 10 is supported.
- KIDX_W, 4, width of the round-key index.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ciphertext block offered.
- in_ready  output  1  block accepted when in_valid && in_ready.
- in_data  input  128  ciphertext. Byte 0 is at [127:120]. Column-major state, matching the round primitives.
- key_idx  output  KIDX_W  index of the round key needed this cycle.
- key_data  input  128  round key[key_idx], valid combinationally in the same cycle.
- out_valid  output  1  plaintext available.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_data  output  128  plaintext (state register).

## Operation
- FSM states: IDLE, ROUND, FINAL, DONE. Round counter rnd[3:0] and 128-bit state register st.
- **IDLE**
  - in_ready=1 and key_idx=NR.
  - On in_valid: st <= in_data ^ key_data, rnd <= NR-1, then go to ROUND.
- **ROUND**
  - key_idx=rnd.
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ key_data).
  - rnd <= rnd-1.
  - When rnd==1, go to FINAL.
- **FINAL**
  - key_idx=0.
  - st <= InvSubBytes(InvShiftRows(st)) ^ key_data. No InvMixColumns.
  - Go to DONE.
- **DONE**
  - out_valid=1, key_idx=0, st held.
  - On out_ready: go to IDLE.
- in_ready=0 in ROUND, FINAL and DONE. A new block is never accepted in the same cycle as an output handshake.
- in_data and key_data are sampled only in the states listed above. Changes on key_data at other times are ignored.
- out_data=st in every state. Its contents are defined only while out_valid=1.
- **Reset**
  - Asserting rst at any time, including mid-round, forces IDLE, rnd=0, st=0 and out_valid=0.
  - in_ready is forced to 0 while rst is high and becomes 1 in the first cycle after deassertion.
  - A block in flight at reset is discarded with no output.

## Timing
- Acceptance edge is cycle 0. ROUND occupies cycles 1–9 (rnd 9→1), FINAL is cycle 10, and out_valid rises after the cycle-10 edge. That is 11 cycles of latency.
- Minimum spacing between acceptances is 12 cycles: accept, 10 compute cycles, 1 DONE cycle when out_ready is already high.
- out_valid, out_data and in_ready are driven from registered state only; there is no combinational path from in_valid or out_ready.
- key_idx is decoded from FSM state and rnd; the key store must return key_data in the same cycle.
- out_valid stays high and out_data stays stable until the handshake completes.

## Configuration
- Macro: `AES_INV_CTRL_ABORT_EN`.
- **Defined**
  - Adds input `abort` (1 bit).
  - abort=1 in ROUND, FINAL or DONE returns the block to IDLE on the next edge with st cleared and no output handshake.
  - abort in IDLE has no effect. abort takes priority over the out_ready handshake in the same cycle.
- **Undefined**
  - The port is absent and the FSM has no abort path.

## Structure
- Shared package `aes_pkg` holds:
  - constants NR=10 and KIDX_W=4;
  - enum `inv_ctrl_state_t` {IDLE, ROUND, FINAL, DONE};
  - typedef `aes_block_t` = logic [127:0].
- One natural sub-module, `aes_inv_round`. It is combinational; inputs are st, rkey and a last-round flag. It instantiates the existing inverse ShiftRows, SubBytes and MixColumns primitives and bypasses InvMixColumns when the flag is set.
- The controller holds only the FSM, rnd, st and handshake logic.

## Test plan
- **FIPS-197 C.1 vector.** Key 000102…0f (bench-expanded round keys). in_data 69c4e0d86a7b0430d8cdb78070b4c55a. Expect out_data 00112233445566778899aabbccddeeff, with out_valid exactly 11 cycles after acceptance.
- **Key index sequence.** key_idx is 10 at acceptance, then 9,8,…,1 in ROUND, then 0 in FINAL, checked cycle by cycle.
- **Output backpressure.** Hold out_ready=0 for 20 cycles after out_valid. out_data stays stable, in_ready=0, and in_valid pulses are ignored. Release out_ready: IDLE next cycle, and the next acceptance is at the earliest the cycle after.
- **Back-to-back blocks.** Two C.1 blocks with in_valid held high and out_ready=1. Acceptances are 12 cycles apart and both outputs are correct.
- **Reset mid-operation.** Assert rst during ROUND rnd=5. out_valid=0 and in_ready=0 immediately. After release, in_ready=1, and a fresh C.1 block decrypts correctly.
- **Abort (`AES_INV_CTRL_ABORT_EN` only).** abort at cycle 4 after acceptance: no out_valid, IDLE next cycle, st=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, inverse-controller state encoding and
// the GF(2^8) helpers used by the inverse round primitives.
package aes_pkg;

    localparam int NR     = 10;
    localparam int KIDX_W = 4;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } inv_ctrl_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

endpackage

// File: rtl/aes_inv_cipher_ctrl_if.sv
// Block-in / block-out handshakes plus the round-key fetch port of the
// inverse cipher controller.
interface aes_inv_cipher_ctrl_if;
    import aes_pkg::*;

    logic              in_valid;
    logic              in_ready;
    aes_block_t        in_data;
    logic [KIDX_W-1:0] key_idx;
    aes_block_t        key_data;
    logic              out_valid;
    logic              out_ready;
    aes_block_t        out_data;

    modport master (
        output in_valid, in_data, key_data, out_ready,
        input  in_ready, key_idx, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, key_data, out_ready,
        output in_ready, key_idx, out_valid, out_data
    );

endinterface

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey and,
// unless last is set, InvMixColumns. Byte 0 sits at [127:120], column-major.
module aes_inv_shift_rows
    import aes_pkg::*;
(
    input  aes_block_t din,
    output aes_block_t dout
);
    // Row r rotates right by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c-r+4)%4)) -: 8];
        end
    end
endmodule

module aes_inv_sub_bytes
    import aes_pkg::*;
(
    input  aes_block_t din,
    output aes_block_t dout
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[127-8*i -: 8] = inv_sbox(din[127-8*i -: 8]);
    end
endmodule

module aes_inv_mix_columns
    import aes_pkg::*;
(
    input  aes_block_t din,
    output aes_block_t dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[127-32*c -: 8];
        assign a1 = din[119-32*c -: 8];
        assign a2 = din[111-32*c -: 8];
        assign a3 = din[103-32*c -: 8];
        assign dout[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        assign dout[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        assign dout[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        assign dout[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
endmodule

module aes_inv_round
    import aes_pkg::*;
(
    input  aes_block_t st,
    input  aes_block_t rkey,
    input  logic       last,
    output aes_block_t dout
);
    aes_block_t sr, sb, ark, mc;

    aes_inv_shift_rows  u_isr (.din(st),  .dout(sr));
    aes_inv_sub_bytes   u_isb (.din(sr),  .dout(sb));
    assign ark = sb ^ rkey;
    aes_inv_mix_columns u_imc (.din(ark), .dout(mc));

    assign dout = last ? ark : mc;
endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 decryption sequencer, one inverse round per clock.
// Optional abort input enabled by defining AES_INV_CTRL_ABORT_EN.
module aes_inv_cipher_ctrl
    import aes_pkg::*;
(
    input  logic clk,
    input  logic rst,
`ifdef AES_INV_CTRL_ABORT_EN
    input  logic abort,
`endif
    aes_inv_cipher_ctrl_if.slave bus
);

    inv_ctrl_state_t   state, nstate;
    logic [KIDX_W-1:0] rnd;
    aes_block_t        st;
    aes_block_t        round_out;
    logic              rdy;
    logic              kill;
    logic              accept;
    logic              last_round;

`ifdef AES_INV_CTRL_ABORT_EN
    assign kill = abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    assign accept     = (state == IDLE) && rdy && bus.in_valid;
    assign last_round = (state == FINAL);

    aes_inv_round u_round (
        .st   (st),
        .rkey (bus.key_data),
        .last (last_round),
        .dout (round_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rdy   <= 1'b0;
        end else begin
            state <= nstate;
            // in_ready is a register so it stays low through reset and
            // never depends combinationally on the handshake inputs.
            rdy   <= (nstate == IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd <= '0;
            st  <= '0;
        end else if (kill) begin
            st  <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    st  <= bus.in_data ^ bus.key_data;
                    rnd <= KIDX_W'(NR - 1);
                end
                ROUND: begin
                    st  <= round_out;
                    rnd <= rnd - KIDX_W'(1);
                end
                FINAL: st <= round_out;
                default: ;
            endcase
        end
    end

    // NOTE: nstate gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = ROUND;
            ROUND:   if (rnd == KIDX_W'(1)) nstate = FINAL;
            FINAL:   nstate = DONE;
            DONE:    if (bus.out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (kill) nstate = IDLE;
    end

    always_comb begin
        bus.key_idx   = '0;
        bus.in_ready  = rdy;
        bus.out_valid = (state == DONE);
        bus.out_data  = st;
        unique case (state)
            IDLE:    bus.key_idx = KIDX_W'(NR);
            ROUND:   bus.key_idx = rnd;
            default: bus.key_idx = '0;
        endcase
    end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Self-checking bench for aes_inv_cipher_ctrl: known-answer vectors with
// bench-expanded keys, key index sequencing, backpressure, reset and abort.
module tb_aes_inv_cipher_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef AES_INV_CTRL_ABORT_EN
    logic abort = 1'b0;
`endif

    aes_inv_cipher_ctrl_if bus ();

    aes_inv_cipher_ctrl dut (
        .clk   (clk),
        .rst   (rst),
`ifdef AES_INV_CTRL_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc = 0;
    int acc_n    = 0;
    int gap      = 0;
    logic prev_ov = 1'b0;

    aes_block_t exp_q[$];
    aes_block_t rk [0:10];
    logic [7:0] sb [256];

    localparam aes_block_t C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_block_t C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam aes_block_t C1_PT  = 128'h00112233445566778899aabbccddeeff;

    assign bus.key_data = (bus.key_idx <= 4'd10) ? rk[bus.key_idx] : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference S-box built by brute-force inversion and the forward affine map.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic init_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input aes_block_t key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: acceptance timing, output latency and the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                if (acc_n > 0) gap <= cyc - last_acc;
                last_acc <= cyc;
                acc_n    <= acc_n + 1;
            end
            if (bus.out_valid && !prev_ov) check("latency", cyc - last_acc, 11);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", bus.out_valid, 1'b0);
                else check("out_data", bus.out_data, exp_q.pop_front());
            end
        end
        prev_ov <= bus.out_valid;
    end

    task automatic send(input aes_block_t ct, input aes_block_t pt);
        int n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = ct;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        check("accept", bus.in_ready, 1'b1);
        exp_q.push_back(pt);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!bus.out_valid && n < 40) begin @(negedge clk); n++; end
        check("out_valid_seen", bus.out_valid, 1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        aes_block_t key;
        aes_block_t ct;
        aes_block_t pt;
    } vec_t;

    typedef struct {
        logic [3:0] kidx;
        logic       rdy;
        logic       ov;
    } step_t;

    vec_t  vecs [3];
    step_t steps [12];

    initial begin
        int cnt;
        logic seen;

        vecs[0] = '{C1_KEY, C1_CT, C1_PT};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};
        steps[0] = '{4'd10, 1'b1, 1'b0};
        for (int k = 1; k <= 9; k++) steps[k] = '{4'(10 - k), 1'b0, 1'b0};
        steps[10] = '{4'd0, 1'b0, 1'b0};
        steps[11] = '{4'd0, 1'b0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        init_sbox();
        expand_key(C1_KEY);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        check("idle_key_idx", bus.key_idx, 4'd10);

        // Cycle-by-cycle key index, ready and valid after acceptance
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = C1_CT;
        exp_q.push_back(C1_PT);
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("key_idx_c%0d", k), bus.key_idx, steps[k].kidx);
            check($sformatf("in_ready_c%0d", k), bus.in_ready, steps[k].rdy);
            check($sformatf("out_valid_c%0d", k), bus.out_valid, steps[k].ov);
            if (k == 0) begin @(posedge clk); #1 bus.in_valid = 1'b0; end
        end
        wait_drain();

        // Known-answer vectors
        for (int v = 0; v < 3; v++) begin
            expand_key(vecs[v].key);
            send(vecs[v].ct, vecs[v].pt);
            wait_drain();
        end
        expand_key(C1_KEY);

        // Output backpressure
        bus.out_ready = 1'b0;
        send(C1_CT, C1_PT);
        wait_out_valid();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.in_valid = i[0];
            bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_out_data", bus.out_data, C1_PT);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_in_ready", bus.in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_in_ready", bus.in_ready, 1'b1);
        check("bp_idle_out_valid", bus.out_valid, 1'b0);
        check("bp_idle_key_idx", bus.key_idx, 4'd10);
        check("bp_drained", exp_q.size(), 0);

        // Back-to-back with in_valid held high
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = C1_CT;
        exp_q.push_back(C1_PT);
        exp_q.push_back(C1_PT);
        cnt = 0;
        for (int n = 0; n < 60 && cnt < 2; n++) begin
            @(negedge clk);
            if (bus.in_ready) cnt++;
        end
        check("b2b_accepts", cnt, 2);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_gap", gap, 12);
        wait_drain();

        // Reset during ROUND with rnd=5
        send(C1_CT, C1_PT);
        repeat (5) @(negedge clk);
        check("pre_rst_key_idx", bus.key_idx, 4'd5);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b0);
        check("mid_rst_out_data", bus.out_data, '0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", bus.in_ready, 1'b1);
        send(C1_CT, C1_PT);
        wait_drain();

`ifdef AES_INV_CTRL_ABORT_EN
        // Abort in cycle 4 after acceptance
        send(C1_CT, C1_PT);
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_in_ready", bus.in_ready, 1'b1);
        check("abort_st", bus.out_data, '0);
        check("abort_key_idx", bus.key_idx, 4'd10);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check("abort_no_output", seen, 1'b0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at t=%0t", $time);
        $fatal(1);
    end

endmodule
